// File: rtl/uart_rx_if.sv
// Character-level view of the UART receiver: serial line and read strobe in,
// held character and status flags out.
interface uart_rx_if;
    logic       rxd;
    logic       rd;
    logic [7:0] data_out;
    logic       rx_rdy;
    logic       pe_fg;
    logic       fe_fg;
    logic       oe_fg;
    logic       busy;

    modport master (output rxd, rd, input data_out, rx_rdy, pe_fg, fe_fg, oe_fg, busy);
    modport slave  (input rxd, rd, output data_out, rx_rdy, pe_fg, fe_fg, oe_fg, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// The line is synchronized and sampled mid-bit by a down-counting bit timer.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2);
    // The expiry cycle is itself part of the bit period, hence the minus one.
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;

    state_e          state_q, state_d;
    logic            sync_q, rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d, data_q, data_d;
    logic            perr_q, perr_d;
    logic            rdy_q, rdy_d, pe_q, pe_d, fe_q, fe_d, oe_q, oe_d;
    logic            tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        oe_d    = oe_q;
        if (rdy_q && bus.rd) begin
            rdy_d = 1'b0;
            oe_d  = 1'b0;
        end
        case (state_q)
            IDLE: if (!rxs_q) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                if (rxs_q) state_d = IDLE;
                else begin
                    state_d = DATA;
                    cnt_d   = RELOAD;
                    bit_d   = 3'd0;
                end
            end else cnt_d = cnt_q - CW'(1);
            DATA: if (tick) begin
                shift_d = {rxs_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                cnt_d   = RELOAD;
                if (bit_q == 3'd7) begin
                    perr_d  = 1'b0;
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end else cnt_d = cnt_q - CW'(1);
            PARITY: if (tick) begin
                perr_d  = ((^shift_q) ^ rxs_q) != PARITY_ODD;
                cnt_d   = RELOAD;
                state_d = STOP;
            end else cnt_d = cnt_q - CW'(1);
            STOP: if (tick) begin
                data_d  = shift_q;
                pe_d    = PARITY_EN ? perr_q : 1'b0;
                fe_d    = ~rxs_q;
                rdy_d   = 1'b1;
                // A same-cycle read consumes the old character, so no overrun.
                oe_d    = bus.rd ? 1'b0 : (rdy_q ? 1'b1 : oe_q);
                state_d = rxs_q ? IDLE : BREAK;
            end else cnt_d = cnt_q - CW'(1);
            BREAK: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            data_q  <= 8'h00;
            rdy_q   <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= bus.rxd;
            rxs_q   <= sync_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            oe_q    <= oe_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.rx_rdy   = rdy_q;
    assign bus.pe_fg    = pe_q;
    assign bus.fe_fg    = fe_q;
    assign bus.oe_fg    = oe_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Drives serial frames into an even-parity and an odd-parity receiver in
// parallel and compares both against a character-level model.
module tb_uart_rx;
    localparam int C   = 16;
    localparam int LAT = 2 + C/2 + 10*C + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus0();
    uart_rx_if bus1();
    assign bus1.rxd = bus0.rxd;
    assign bus1.rd  = bus0.rd;

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_data;
    logic       m_rdy, m_pe0, m_pe1, m_fe, m_oe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rst_at: frame bit index (0 = start) in whose middle reset is raised.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int rst_at);
        logic [10:0] fr;
        fr = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus0.rxd = fr[i];
            if (i == rst_at) begin
                tick_n(C/2);
                rst = 1'b1;
                tick_n(C - C/2);
            end else tick_n(C);
        end
    endtask

    task automatic model_done(input logic [7:0] d, input logic par, input logic stop, input logic rd_c);
        m_data = d;
        m_pe0  = (^d) ^ par;
        m_pe1  = ~((^d) ^ par);
        m_fe   = ~stop;
        if (rd_c) m_oe = 1'b0;
        else if (m_rdy) m_oe = 1'b1;
        m_rdy  = 1'b1;
    endtask

    task automatic model_clear;
        m_data = 8'h00; m_rdy = 1'b0; m_pe0 = 1'b0; m_pe1 = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data0"}, 32'(bus0.data_out), 32'(m_data));
        chk({tag, ".rdy0"},  32'(bus0.rx_rdy),   32'(m_rdy));
        chk({tag, ".pe0"},   32'(bus0.pe_fg),    32'(m_pe0));
        chk({tag, ".fe0"},   32'(bus0.fe_fg),    32'(m_fe));
        chk({tag, ".oe0"},   32'(bus0.oe_fg),    32'(m_oe));
        chk({tag, ".data1"}, 32'(bus1.data_out), 32'(m_data));
        chk({tag, ".rdy1"},  32'(bus1.rx_rdy),   32'(m_rdy));
        chk({tag, ".pe1"},   32'(bus1.pe_fg),    32'(m_pe1));
        chk({tag, ".oe1"},   32'(bus1.oe_fg),    32'(m_oe));
    endtask

    task automatic pulse_rd(input string tag);
        bus0.rd = 1'b1;
        tick_n(1);
        bus0.rd = 1'b0;
        if (m_rdy) begin m_rdy = 1'b0; m_oe = 1'b0; end
        check_all(tag);
    endtask

    // rd_c raises rd so that it is sampled on the completion cycle.
    task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop, input logic rd_c);
        fork
            send_frame(d, par, stop, -1);
            if (rd_c) begin
                tick_n(LAT);
                bus0.rd = 1'b1;
                tick_n(1);
                bus0.rd = 1'b0;
            end
        join
        model_done(d, par, stop, rd_c);
        bus0.rxd = 1'b1;
        tick_n(4);
    endtask

    initial begin
        int c;
        logic [7:0] d;
        logic par, stop;
        int mode;

        bus0.rxd = 1'b1;
        bus0.rd  = 1'b0;
        model_clear();
        tick_n(5);
        check_all("reset");
        chk("reset.busy", 32'(bus0.busy), 32'd0);
        rst = 1'b0;
        tick_n(4);

        // A5, correct parity: latency from the first edge sampling the start bit
        c = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1, -1);
            while (!bus0.rx_rdy && c < 400) begin
                @(posedge clk); #1;
                c++;
            end
        join
        chk("a5.latency", 32'(c), 32'(LAT + 1));
        model_done(8'hA5, 1'b0, 1'b1, 1'b0);
        tick_n(4);
        check_all("a5");
        pulse_rd("a5.rd");

        rx_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check_all("par01");
        pulse_rd("par01.rd");

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        model_done(8'h3C, 1'b0, 1'b0, 1'b0);
        tick_n(40);
        chk("brk.busy_low", 32'(bus0.busy), 32'd1);
        bus0.rxd = 1'b1;
        tick_n(2);
        chk("brk.busy_hold", 32'(bus0.busy), 32'd1);
        tick_n(1);
        chk("brk.busy_done", 32'(bus0.busy), 32'd0);
        check_all("brk");
        pulse_rd("brk.rd");

        // False start
        bus0.rxd = 1'b0;
        tick_n(4);
        bus0.rxd = 1'b1;
        chk("glitch.busy_on", 32'(bus0.busy), 32'd1);
        tick_n(20);
        chk("glitch.busy_off", 32'(bus0.busy), 32'd0);
        check_all("glitch");

        rx_frame(8'h11, 1'b0, 1'b1, 1'b0);
        rx_frame(8'h22, 1'b0, 1'b1, 1'b0);
        check_all("ovr");
        pulse_rd("ovr.rd");
        rx_frame(8'h33, 1'b0, 1'b1, 1'b1);
        check_all("rdcol");

        // Reset in the middle of data bit 3, released once the line idles
        send_frame(8'hF0, 1'b0, 1'b1, 4);
        tick_n(2);
        model_clear();
        check_all("midrst");
        chk("midrst.busy", 32'(bus0.busy), 32'd0);
        rst = 1'b0;
        tick_n(4);
        rx_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_all("after_rst");
        pulse_rd("after_rst.rd");

        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            rx_frame(d, par, stop, mode == 1);
            check_all($sformatf("rnd%0d", i));
            if (mode == 2) pulse_rd($sformatf("rnd%0d.rd", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
